// File: rtl/alu_pkg.sv
// Shared definitions for the streaming ALU.
// Holds the opcode encoding, the FSM state type and a reference function
// alu_expected() that computes result and flags for any width up to MAXW.
// Monitors and checkers call alu_expected() to predict the unit's output.
package alu_pkg;

    localparam int OPW  = 3;
    localparam int MAXW = 32;

    localparam logic [OPW-1:0] OP_ADD = 3'd0;
    localparam logic [OPW-1:0] OP_SUB = 3'd1;
    localparam logic [OPW-1:0] OP_MUL = 3'd2;
    localparam logic [OPW-1:0] OP_DIV = 3'd3;
    localparam logic [OPW-1:0] OP_AND = 3'd4;
    localparam logic [OPW-1:0] OP_NOT = 3'd5;
    localparam logic [OPW-1:0] OP_OR  = 3'd6;
    localparam logic [OPW-1:0] OP_XOR = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_DIV_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [MAXW-1:0] y;
        logic            carry;
        logic            zero;
        logic            dz;
    } alu_res_t;

    // Operands are taken as unsigned values truncated to 'width' bits.
    function automatic alu_res_t alu_expected(input logic [MAXW-1:0] a,
                                              input logic [MAXW-1:0] b,
                                              input logic [OPW-1:0]  op,
                                              input int              width);
        logic [2*MAXW-1:0] mask;
        logic [2*MAXW-1:0] wa;
        logic [2*MAXW-1:0] wb;
        logic [2*MAXW-1:0] r;
        alu_res_t          res;
        mask = (64'd1 << width) - 64'd1;
        wa   = {{MAXW{1'b0}}, a} & mask;
        wb   = {{MAXW{1'b0}}, b} & mask;
        r    = '0;
        res  = '0;
        case (op)
            OP_ADD: begin r = wa + wb; res.carry = r[width]; end
            OP_SUB: begin r = wa - wb; res.carry = (wa < wb); end
            OP_MUL: begin r = wa * wb; res.carry = (((r >> width) & mask) != '0); end
            OP_DIV: begin
                if (wb == '0) begin r = '0; res.dz = 1'b1; end
                else          r = wa / wb;
            end
            OP_AND: r = wa & wb;
            OP_NOT: r = ~wa;
            OP_OR:  r = wa | wb;
            OP_XOR: r = wa ^ wb;
            default: r = '0;
        endcase
        r        = r & mask;
        res.y    = r[MAXW-1:0];
        res.zero = (r == '0);
        return res;
    endfunction

endpackage

// File: rtl/alu_stream_unit_if.sv
// Handshake bundle for alu_stream_unit.
// Input side:  in_valid/in_ready with operands in_a, in_b and opcode in_op.
// Output side: out_valid/out_ready with result out_y and flags
//              out_carry, out_zero, out_dz; busy marks divider iteration.
// master = stimulus/consumer side, slave = the ALU.
interface alu_stream_unit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [OPW-1:0]   in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_carry;
    logic             out_zero;
    logic             out_dz;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_carry, out_zero, out_dz, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_carry, out_zero, out_dz, busy
    );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Ports: clk, reset (async, active-high), start (load operands),
//        dividend, divisor, done (high in the cycle the last bit is formed),
//        quotient (valid while done is high).
// The last iteration is presented combinationally so the caller can capture
// the quotient on the same edge that completes the division.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH);

    logic             active_q,  active_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [WIDTH-1:0] rem_q,     rem_d;
    logic [WIDTH-1:0] quo_q,     quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             last;

    // NOTE: every always_comb output gets a default first and uses blocking
    // assignments, so no path leaves a signal unassigned (no latch).
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        fits      = (rem_shift >= {1'b0, divisor_q});
        // When the divisor fits, the true difference is below 2^WIDTH.
        diff      = rem_shift[WIDTH-1:0] - divisor_q;
        step_rem  = fits ? diff : rem_shift[WIDTH-1:0];
        step_quo  = {quo_q[WIDTH-2:0], fits};
        last      = (count_q == CW'(WIDTH - 1));

        active_d  = active_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;

        if (start) begin
            active_d  = 1'b1;
            count_d   = '0;
            rem_d     = '0;
            quo_d     = dividend;
            divisor_d = divisor;
        end else if (active_q) begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            count_d = count_q + CW'(1);
            if (last) active_d = 1'b0;
        end
    end

    assign done     = active_q && last;
    assign quotient = step_quo;

    // NOTE: sequential state uses non-blocking assignments only. The datapath
    // registers are reset too, so a reset mid-divide leaves no partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q  <= 1'b0;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
        end else begin
            active_q  <= active_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
        end
    end

endmodule

// File: rtl/alu_stream_unit.sv
// Streaming ALU with valid/ready handshakes on input and output.
// Ports: clk, reset (async, active-high), bus (alu_stream_unit_if.slave)
//        carrying the operand beat, the result beat, flags and busy.
// Single-cycle ops load result and flags on the accept edge. DIV with a
// nonzero divisor runs seq_divider for WIDTH cycles; DIV by zero completes
// in one cycle with out_dz set.
module alu_stream_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    alu_stream_unit_if.slave   bus
);

    state_t           state_q,     state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_y_q,     out_y_d;
    logic             carry_q,     carry_d;
    logic             zero_q,      zero_d;
    logic             dz_q,        dz_d;

    logic             accept;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quotient;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_carry;
    logic               alu_dz;

    // Combinational from out_ready: a retiring result frees the slot now.
    assign bus.in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign div_start    = accept && (bus.in_op == OP_DIV) && (bus.in_b != '0);

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (bus.in_a),
        .divisor  (bus.in_b),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Single-cycle datapath; DIV here only covers the divide-by-zero case.
    always_comb begin
        sum       = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        prod      = {{WIDTH{1'b0}}, bus.in_a} * {{WIDTH{1'b0}}, bus.in_b};
        alu_y     = '0;
        alu_carry = 1'b0;
        alu_dz    = 1'b0;
        case (bus.in_op)
            OP_ADD: begin alu_y = sum[WIDTH-1:0]; alu_carry = sum[WIDTH]; end
            OP_SUB: begin alu_y = bus.in_a - bus.in_b; alu_carry = (bus.in_a < bus.in_b); end
            OP_MUL: begin alu_y = prod[WIDTH-1:0]; alu_carry = |prod[2*WIDTH-1:WIDTH]; end
            OP_DIV: alu_dz = (bus.in_b == '0);
            OP_AND: alu_y = bus.in_a & bus.in_b;
            OP_NOT: alu_y = ~bus.in_a;
            OP_OR:  alu_y = bus.in_a | bus.in_b;
            OP_XOR: alu_y = bus.in_a ^ bus.in_b;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        dz_d        = dz_q;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (div_start) begin
                    state_d = ST_DIV_BUSY;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    out_y_d     = alu_y;
                    carry_d     = alu_carry;
                    zero_d      = (alu_y == '0);
                    dz_d        = alu_dz;
                end
            end
            ST_DIV_BUSY: begin
                // out_valid is already clear here: entry required a free slot.
                if (div_done) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    out_y_d     = div_quotient;
                    carry_d     = 1'b0;
                    zero_d      = (div_quotient == '0);
                    dz_d        = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            dz_q        <= dz_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_carry = carry_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_dz    = dz_q;
    assign bus.busy      = (state_q == ST_DIV_BUSY);

endmodule

// File: tb/tb_alu_stream_unit.sv
// Directed testbench for alu_stream_unit: a WIDTH=4 instance for the small
// arithmetic vectors and a WIDTH=8 instance for divide, backpressure,
// streaming and reset-mid-divide. Inputs change 1 time unit after the rising
// edge; outputs are sampled at the same point.
module tb_alu_stream_unit;
    import alu_pkg::*;

    logic clk;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    alu_stream_unit_if #(.WIDTH(4)) bus4 ();
    alu_stream_unit_if #(.WIDTH(8)) bus8 ();

    alu_stream_unit #(.WIDTH(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    alu_stream_unit #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An unknown opcode on a valid beat is a source protocol violation.
    always @(posedge clk) begin
        if (!reset && bus8.in_valid)
            assert (!$isunknown(bus8.in_op)) else $error("protocol: unknown opcode on bus8");
        if (!reset && bus4.in_valid)
            assert (!$isunknown(bus4.in_op)) else $error("protocol: unknown opcode on bus4");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        bus4.in_a = a; bus4.in_b = b; bus4.in_op = op; bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus8.in_a = a; bus8.in_b = b; bus8.in_op = op; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
    endtask

    logic [2:0] stream_ops [0:6];
    alu_res_t   exp_r;
    logic [7:0] sa, sb;
    int         seen_valid;

    initial begin
        stream_ops = '{OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_NOT, OP_OR, OP_XOR};
        reset = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_op = OP_ADD; bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_op = OP_ADD; bus8.out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_valid", bus8.out_valid, 0);
        check("rst_y",     bus8.out_y,     0);
        check("rst_flags", {bus8.out_carry, bus8.out_zero, bus8.out_dz}, 0);
        check("rst_busy",  bus8.busy,      0);
        check("rst_valid4", bus4.out_valid, 0);
        reset = 1'b0;
        tick();
        check("idle_ready", bus8.in_ready, 1);

        // WIDTH=4 arithmetic
        check("add4_ready", bus4.in_ready, 1);
        send4(4'd9, 4'd8, OP_ADD);
        check("add4_valid", bus4.out_valid, 1);
        check("add4_y",     bus4.out_y,     1);
        check("add4_carry", bus4.out_carry, 1);
        check("add4_zero",  bus4.out_zero,  0);
        send4(4'd3, 4'd5, OP_SUB);
        check("sub4_y",     bus4.out_y,     14);
        check("sub4_carry", bus4.out_carry, 1);
        send4(4'd5, 4'd4, OP_MUL);
        check("mul4_y",     bus4.out_y,     4);
        check("mul4_carry", bus4.out_carry, 1);
        send4(4'd6, 4'd6, OP_XOR);
        check("xor4_y",     bus4.out_y,     0);
        check("xor4_zero",  bus4.out_zero,  1);
        check("xor4_carry", bus4.out_carry, 0);
        tick();
        check("drain4", bus4.out_valid, 0);

        // DIV 200/7 = 28: busy for 8 cycles, result in cycle 9
        send8(8'd200, 8'd7, OP_DIV);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("div_busy_c%0d", k),  bus8.busy,      1);
            check($sformatf("div_ready_c%0d", k), bus8.in_ready,  0);
            check($sformatf("div_valid_c%0d", k), bus8.out_valid, 0);
            tick();
        end
        check("div_valid", bus8.out_valid, 1);
        check("div_y",     bus8.out_y,     28);
        check("div_dz",    bus8.out_dz,    0);
        check("div_busy_end", bus8.busy,   0);

        // DIV by zero: latency 1
        send8(8'd5, 8'd0, OP_DIV);
        check("dz_valid", bus8.out_valid, 1);
        check("dz_y",     bus8.out_y,     0);
        check("dz_dz",    bus8.out_dz,    1);
        check("dz_zero",  bus8.out_zero,  1);
        check("dz_carry", bus8.out_carry, 0);
        check("dz_busy",  bus8.busy,      0);
        tick();
        check("dz_retired", bus8.out_valid, 0);

        // Backpressure: ADD 1+2 held for 5 cycles while a new beat waits
        bus8.out_ready = 1'b0;
        send8(8'd1, 8'd2, OP_ADD);
        bus8.in_a = 8'hF0; bus8.in_b = 8'h0F; bus8.in_op = OP_XOR; bus8.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_valid_c%0d", k), bus8.out_valid, 1);
            check($sformatf("bp_y_c%0d", k),     bus8.out_y,     3);
            check($sformatf("bp_ready_c%0d", k), bus8.in_ready,  0);
            tick();
        end
        bus8.out_ready = 1'b1;
        #1;
        check("bp_ready_comb", bus8.in_ready, 1);
        tick();
        bus8.in_valid = 1'b0;
        check("bp_new_valid", bus8.out_valid, 1);
        check("bp_new_y",     bus8.out_y,     8'hFF);
        check("bp_new_zero",  bus8.out_zero,  0);
        tick();
        check("bp_drain", bus8.out_valid, 0);

        // Streaming: 16 back-to-back non-DIV beats
        for (int i = 0; i < 16; i++) begin
            sa = 8'(i * 37 + 11);
            sb = 8'(i * 53 + 200);
            bus8.in_a = sa; bus8.in_b = sb; bus8.in_op = stream_ops[i % 7]; bus8.in_valid = 1'b1;
            #1;
            check($sformatf("st_ready_%0d", i), bus8.in_ready, 1);
            exp_r = alu_expected({24'b0, sa}, {24'b0, sb}, stream_ops[i % 7], 8);
            tick();
            check($sformatf("st_valid_%0d", i), bus8.out_valid, 1);
            check($sformatf("st_y_%0d", i),     {24'b0, bus8.out_y}, exp_r.y);
            check($sformatf("st_c_%0d", i),     bus8.out_carry, exp_r.carry);
            check($sformatf("st_z_%0d", i),     bus8.out_zero,  exp_r.zero);
        end
        bus8.in_valid = 1'b0;
        tick();
        check("st_drain", bus8.out_valid, 0);

        // Reset in the 3rd divide cycle abandons the divide
        send8(8'd100, 8'd3, OP_DIV);
        tick();
        tick();
        check("rd_busy_before", bus8.busy, 1);
        reset = 1'b1;
        #1;
        check("rd_valid_async", bus8.out_valid, 0);
        check("rd_busy_async",  bus8.busy,      0);
        tick();
        reset = 1'b0;
        seen_valid = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus8.out_valid) seen_valid++;
            tick();
        end
        check("rd_no_stale", seen_valid, 0);
        send8(8'd2, 8'd2, OP_ADD);
        check("rd_add_valid", bus8.out_valid, 1);
        check("rd_add_y",     bus8.out_y,     4);
        check("rd_add_dz",    bus8.out_dz,    0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_stream_unit.md
Name: alu_stream_unit

Overview:
- Parametrised successor of the team's 4-bit sequential ALU.
- Operand width is generic. Input and output use valid/ready handshakes. The unit reports status flags (carry, zero, divide-by-zero).
- Divide is a multi-cycle restoring divider. All other ops complete in a single cycle.
- Sits between the BFM-driven stimulus stream and downstream result consumers. Monitor and checker attach to both handshake interfaces.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- OPW, 3, opcode width; fixed by the shared package, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  OPW  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 NOT(A), 110 OR, 111 XOR.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WIDTH  result.
- out_carry  out  1  ADD carry-out / SUB borrow / MUL high-half-nonzero; 0 for all other ops.
- out_zero  out  1  out_y == 0.
- out_dz  out  1  DIV with in_b == 0.
- busy  out  1  divider iterating.

Behaviour:
- Reset values (asynchronous reset): state IDLE, out_valid=0, out_y=0, all flags 0, busy=0, divider registers 0.
- Reset mid-divide abandons the operation; no result is produced.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from out_ready.
- Accept occurs when in_valid && in_ready at a rising edge. Operands and op are registered at accept.
- Output holds: while out_valid && !out_ready, out_y and all flags stay stable.
- out_valid clears on out_ready unless a new result loads in the same edge.
- States:
  - IDLE: waiting for a beat.
  - DIV_BUSY: divider iterating.
- Non-DIV ops:
  - Result and flags load on the accept edge; out_valid=1 on the next cycle (latency 1).
  - Back-to-back accepts with out_ready=1 give throughput of 1 beat per cycle.
- DIV with in_b != 0:
  - Accept moves IDLE->DIV_BUSY and busy=1.
  - One quotient bit is produced per cycle, MSB first.
  - After WIDTH iterations the quotient loads into out_y, state returns to IDLE, out_valid=1. Latency is WIDTH+1 cycles from accept.
  - in_ready=0 throughout DIV_BUSY.
- DIV with in_b == 0: no busy phase; latency 1, out_y=0, out_dz=1, out_carry=0.
- Arithmetic (all results modulo 2^WIDTH):
  - ADD: out_carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: out_carry = (a < b), unsigned.
  - MUL: out_y = low WIDTH bits of the 2*WIDTH product; out_carry = |high WIDTH bits.
  - NOT ignores in_b.
  - All operands are unsigned.
- out_zero is computed from the loaded out_y for every op, including DIV-by-zero.
- Simultaneous events: when a DIV completes and out_ready drops in the same cycle, the result is held. When in_valid is high with in_ready=0, the beat is not accepted; the source holds it.
- Unknown op (X) while in_valid is high: treated as a protocol violation; the bench flags it with an assertion.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_XOR;
  - OPW=3;
  - state encoding ST_IDLE/ST_DIV_BUSY;
  - reference-model function alu_expected(a,b,op,WIDTH). The monitor/checker reuse this function.
- Sub-module seq_divider (WIDTH param):
  - ports: start, dividend, divisor, done, quotient;
  - restoring algorithm, WIDTH cycles;
  - top-level FSM handles handshake and flags.

Test Plan:
- WIDTH=4, reset then ADD 9+8 with out_ready=1 -> out_valid 1 cycle after accept, out_y=1, out_carry=1, out_zero=0.
- WIDTH=4, SUB 3-5 -> out_y=14, out_carry=1. MUL 5*4 -> out_y=4, out_carry=1. XOR 6^6 -> out_y=0, out_zero=1.
- WIDTH=8, DIV 200/7 -> busy=1 for 8 cycles, in_ready=0 meanwhile, out_valid at cycle 9 after accept, out_y=28, out_dz=0. Then DIV 5/0 -> latency 1, out_y=0, out_dz=1, out_zero=1.
- Backpressure: ADD 1+2 with out_ready=0 for 5 cycles -> out_y=3 stable, in_ready=0. Raise out_ready with a new beat valid -> new beat accepted on the same edge the old result retires.
- Streaming: 16 back-to-back non-DIV beats with out_ready=1 -> 16 results on consecutive cycles, each matching alu_expected.
- Reset asserted on the 3rd divide cycle -> out_valid=0 and busy=0 immediately. After release, ADD 2+2 -> out_y=4 with no stale DIV result.
